fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 72 +++++++
 rtl/fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bundle of the fetch-queue enqueue, dequeue and status
//               signals. The master modport is the fetch/pre-decode side;
//               the slave modport is the queue itself.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

interface fetch_queue_if #(
  parameter int DEPTH = 8
);
  logic                         flush;
  logic                         stall;
  logic [`IF_BATCH_SIZE-1:0]    in_inst_valid;
  logic [`INST_WIDTH-1:0]       in_inst_0;
  logic [`INST_WIDTH-1:0]       in_inst_1;
  logic [`INST_ADDR_WIDTH-1:0]  in_pc_0;
  logic [`INST_ADDR_WIDTH-1:0]  in_pc_1;
  logic                         in_pred_taken_0;
  logic                         in_pred_taken_1;
  logic [`INST_ADDR_WIDTH-1:0]  in_pred_target_0;
  logic [`INST_ADDR_WIDTH-1:0]  in_pred_target_1;
  logic [`BP_GHR_BITS-1:0]      in_pred_hist_0;
  logic [`BP_GHR_BITS-1:0]      in_pred_hist_1;
  logic                         in_ready;
  logic [`IF_BATCH_SIZE-1:0]    out_inst_valid;
  logic [`INST_WIDTH-1:0]       out_inst_0;
  logic [`INST_WIDTH-1:0]       out_inst_1;
  logic [`INST_ADDR_WIDTH-1:0]  out_pc_0;
  logic [`INST_ADDR_WIDTH-1:0]  out_pc_1;
  logic                         out_pred_taken_0;
  logic                         out_pred_taken_1;
  logic [`INST_ADDR_WIDTH-1:0]  out_pred_target_0;
  logic [`INST_ADDR_WIDTH-1:0]  out_pred_target_1;
  logic [`BP_GHR_BITS-1:0]      out_pred_hist_0;
  logic [`BP_GHR_BITS-1:0]      out_pred_hist_1;
  logic [$clog2(DEPTH):0]       count;

  modport master (
    output flush, stall, in_inst_valid, in_inst_0, in_inst_1, in_pc_0, in_pc_1,
           in_pred_taken_0, in_pred_taken_1, in_pred_target_0, in_pred_target_1,
           in_pred_hist_0, in_pred_hist_1,
    input  in_ready, out_inst_valid, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
           out_pred_taken_0, out_pred_taken_1, out_pred_target_0,
           out_pred_target_1, out_pred_hist_0, out_pred_hist_1, count
  );

  modport slave (
    input  flush, stall, in_inst_valid, in_inst_0, in_inst_1, in_pc_0, in_pc_1,
           in_pred_taken_0, in_pred_taken_1, in_pred_target_0, in_pred_target_1,
           in_pred_hist_0, in_pred_hist_1,
    output in_ready, out_inst_valid, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
           out_pred_taken_0, out_pred_taken_1, out_pred_target_0,
           out_pred_target_1, out_pred_hist_0, out_pred_hist_1, count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-wide instruction fetch queue between fetch and
//               pre-decode. Circular buffer of DEPTH entries holding the
//               instruction, its PC and branch-prediction fields. Input
//               slots are compacted (a lone slot-1 instruction becomes one
//               entry), output is the oldest one or two entries.
//               Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue
//               is empty, incoming instructions appear on the outputs in the
//               same cycle and are only stored if downstream stalls.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  fetch_queue_if.slave fq
);

  localparam int              c_PW    = $clog2(DEPTH);
  localparam int              c_CW    = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  // Entry storage; validity is defined purely by head/tail/count.
  logic [`INST_WIDTH-1:0]      r_inst   [DEPTH];
  logic [`INST_ADDR_WIDTH-1:0] r_pc     [DEPTH];
  logic                        r_taken  [DEPTH];
  logic [`INST_ADDR_WIDTH-1:0] r_target [DEPTH];
  logic [`BP_GHR_BITS-1:0]     r_hist   [DEPTH];

  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic [c_PW-1:0] w_head_p1;
  logic [c_PW-1:0] w_tail_p1;
  logic            w_ready;
  logic [1:0]      w_in_n;
  logic [1:0]      w_q_n;
  logic [1:0]      w_push_n;
  logic [1:0]      w_pop_n;
  logic            w_byp;
  logic            w_wr;

  // Compacted input: slot A is the oldest valid input, slot B the second.
  logic [`INST_WIDTH-1:0]      w_a_inst;
  logic [`INST_ADDR_WIDTH-1:0] w_a_pc;
  logic                        w_a_taken;
  logic [`INST_ADDR_WIDTH-1:0] w_a_target;
  logic [`BP_GHR_BITS-1:0]     w_a_hist;

  assign w_head_p1 = r_head + c_PW'(1);
  assign w_tail_p1 = r_tail + c_PW'(1);

  // Ready depends only on registered occupancy so it never loops back
  // through the producer's valid logic.
  assign w_ready     = (c_DEPTH - r_count) >= c_CW'(2);
  assign fq.in_ready = w_ready;
  assign fq.count    = r_count;

  assign w_in_n = {1'b0, fq.in_inst_valid[0]} + {1'b0, fq.in_inst_valid[1]};
  assign w_q_n  = (r_count >= c_CW'(2)) ? 2'd2 : r_count[1:0];

  // Select slot 0 when valid, otherwise slot 1 shifts down into slot A.
  always_comb begin
    w_a_inst   = fq.in_inst_0;
    w_a_pc     = fq.in_pc_0;
    w_a_taken  = fq.in_pred_taken_0;
    w_a_target = fq.in_pred_target_0;
    w_a_hist   = fq.in_pred_hist_0;
    if (!fq.in_inst_valid[0]) begin
      w_a_inst   = fq.in_inst_1;
      w_a_pc     = fq.in_pc_1;
      w_a_taken  = fq.in_pred_taken_1;
      w_a_target = fq.in_pred_target_1;
      w_a_hist   = fq.in_pred_hist_1;
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = rst_n && (r_count == '0) && !fq.flush && (w_in_n != 2'd0);
`else
  assign w_byp = 1'b0;
`endif

  // Bypassed instructions that downstream takes this cycle are not stored.
  assign w_wr     = w_ready && !fq.flush && !(w_byp && !fq.stall);
  assign w_push_n = w_wr ? w_in_n : 2'd0;
  assign w_pop_n  = (!fq.stall && !fq.flush) ? w_q_n : 2'd0;

  // Data storage write at the tail; no reset needed as pointers gate use.
  always_ff @(posedge clk) begin
    if (w_push_n != 2'd0) begin
      r_inst[r_tail]   <= w_a_inst;
      r_pc[r_tail]     <= w_a_pc;
      r_taken[r_tail]  <= w_a_taken;
      r_target[r_tail] <= w_a_target;
      r_hist[r_tail]   <= w_a_hist;
    end
    if (w_push_n == 2'd2) begin
      r_inst[w_tail_p1]   <= fq.in_inst_1;
      r_pc[w_tail_p1]     <= fq.in_pc_1;
      r_taken[w_tail_p1]  <= fq.in_pred_taken_1;
      r_target[w_tail_p1] <= fq.in_pred_target_1;
      r_hist[w_tail_p1]   <= fq.in_pred_hist_1;
    end
  end

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (fq.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PW'(w_pop_n);
      r_tail  <= r_tail + c_PW'(w_push_n);
      r_count <= r_count + c_CW'(w_push_n) - c_CW'(w_pop_n);
    end
  end

  // Head presentation; unused slots are forced to zero.
  always_comb begin
    fq.out_inst_valid    = '0;
    fq.out_inst_0        = '0;
    fq.out_inst_1        = '0;
    fq.out_pc_0          = '0;
    fq.out_pc_1          = '0;
    fq.out_pred_taken_0  = 1'b0;
    fq.out_pred_taken_1  = 1'b0;
    fq.out_pred_target_0 = '0;
    fq.out_pred_target_1 = '0;
    fq.out_pred_hist_0   = '0;
    fq.out_pred_hist_1   = '0;
    if (w_byp) begin
      fq.out_inst_valid[0] = 1'b1;
      fq.out_inst_0        = w_a_inst;
      fq.out_pc_0          = w_a_pc;
      fq.out_pred_taken_0  = w_a_taken;
      fq.out_pred_target_0 = w_a_target;
      fq.out_pred_hist_0   = w_a_hist;
      if (w_in_n == 2'd2) begin
        fq.out_inst_valid[1] = 1'b1;
        fq.out_inst_1        = fq.in_inst_1;
        fq.out_pc_1          = fq.in_pc_1;
        fq.out_pred_taken_1  = fq.in_pred_taken_1;
        fq.out_pred_target_1 = fq.in_pred_target_1;
        fq.out_pred_hist_1   = fq.in_pred_hist_1;
      end
    end else begin
      if (r_count != '0) begin
        fq.out_inst_valid[0] = 1'b1;
        fq.out_inst_0        = r_inst[r_head];
        fq.out_pc_0          = r_pc[r_head];
        fq.out_pred_taken_0  = r_taken[r_head];
        fq.out_pred_target_0 = r_target[r_head];
        fq.out_pred_hist_0   = r_hist[r_head];
      end
      if (r_count >= c_CW'(2)) begin
        fq.out_inst_valid[1] = 1'b1;
        fq.out_inst_1        = r_inst[w_head_p1];
        fq.out_pc_1          = r_pc[w_head_p1];
        fq.out_pred_taken_1  = r_taken[w_head_p1];
        fq.out_pred_target_1 = r_target[w_head_p1];
        fq.out_pred_hist_1   = r_hist[w_head_p1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (DEPTH=8,
//               default build without same-cycle bypass).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

module tb_fetch_queue;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fetch_queue_if #(.DEPTH(8)) fq ();

  fetch_queue #(.DEPTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-PC reference encodings for the payload fields.
  function automatic logic [`INST_WIDTH-1:0] f_inst(input logic [31:0] pc);
    return `INST_WIDTH'(pc ^ 32'hA5A5_0000);
  endfunction
  function automatic logic [`INST_ADDR_WIDTH-1:0] f_tgt(input logic [31:0] pc);
    return `INST_ADDR_WIDTH'(pc + 32'h40);
  endfunction
  function automatic logic [`BP_GHR_BITS-1:0] f_hist(input logic [31:0] pc);
    return `BP_GHR_BITS'(pc[9:2] ^ 8'h3C);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    fq.in_inst_valid    = v;
    fq.in_pc_0          = `INST_ADDR_WIDTH'(pc0);
    fq.in_pc_1          = `INST_ADDR_WIDTH'(pc1);
    fq.in_inst_0        = f_inst(pc0);
    fq.in_inst_1        = f_inst(pc1);
    fq.in_pred_taken_0  = pc0[2];
    fq.in_pred_taken_1  = pc1[2];
    fq.in_pred_target_0 = f_tgt(pc0);
    fq.in_pred_target_1 = f_tgt(pc1);
    fq.in_pred_hist_0   = f_hist(pc0);
    fq.in_pred_hist_1   = f_hist(pc1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] in_pc;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    fq.flush = 1'b0;
    fq.stall = 1'b0;
    drive(2'b00, 32'h0, 32'h0);

    // Reset state
    #2;
    check("rst_valid", 64'(fq.out_inst_valid), 64'h0);
    check("rst_count", 64'(fq.count), 64'h0);
    check("rst_ready", 64'(fq.in_ready), 64'h1);
    check("rst_pc0", 64'(fq.out_pc_0), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Pair push, visible next cycle, drained the cycle after
    drive(2'b11, 32'h100, 32'h104);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("pair_valid", 64'(fq.out_inst_valid), 64'h3);
    check("pair_pc0", 64'(fq.out_pc_0), 64'h100);
    check("pair_pc1", 64'(fq.out_pc_1), 64'h104);
    check("pair_inst0", 64'(fq.out_inst_0), 64'(f_inst(32'h100)));
    check("pair_count", 64'(fq.count), 64'h2);
    tick();
    check("pair_drained_cnt", 64'(fq.count), 64'h0);
    check("pair_drained_vld", 64'(fq.out_inst_valid), 64'h0);

    // Fill to full under stall, overflow ignored, then drain in order
    fq.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i));
      tick();
    end
    check("full_count", 64'(fq.count), 64'h8);
    check("full_ready", 64'(fq.in_ready), 64'h0);
    drive(2'b11, 32'h300, 32'h304);
    tick();
    check("overflow_count", 64'(fq.count), 64'h8);
    drive(2'b00, 32'h0, 32'h0);
    fq.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(fq.out_inst_valid), 64'h3);
      check("drain_pc0", 64'(fq.out_pc_0), 64'(32'h200 + 32'(8 * i)));
      check("drain_pc1", 64'(fq.out_pc_1), 64'(32'h204 + 32'(8 * i)));
      tick();
    end
    check("drain_empty_cnt", 64'(fq.count), 64'h0);
    check("drain_empty_vld", 64'(fq.out_inst_valid), 64'h0);

    // Lone slot-1 instruction is compacted into slot 0
    fq.stall = 1'b1;
    drive(2'b10, 32'hDEAD, 32'h204);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("single_valid", 64'(fq.out_inst_valid), 64'h1);
    check("single_pc0", 64'(fq.out_pc_0), 64'h204);
    check("single_pc1", 64'(fq.out_pc_1), 64'h0);
    check("single_inst1", 64'(fq.out_inst_1), 64'h0);
    check("single_count", 64'(fq.count), 64'h1);
    fq.stall = 1'b0;
    tick();
    check("single_drained", 64'(fq.count), 64'h0);

    // Build occupancy 5, then steady push2/pop2 across pointer wrap
    fq.stall = 1'b1;
    drive(2'b01, 32'h400, 32'h0);
    tick();
    drive(2'b11, 32'h404, 32'h408);
    tick();
    drive(2'b11, 32'h40C, 32'h410);
    tick();
    check("five_count", 64'(fq.count), 64'h5);
    fq.stall = 1'b0;
    exp_pc = 32'h400;
    in_pc  = 32'h414;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, in_pc, in_pc + 32'h4);
      in_pc = in_pc + 32'h8;
      check("steady_count", 64'(fq.count), 64'h5);
      check("steady_pc0", 64'(fq.out_pc_0), 64'(exp_pc));
      check("steady_pc1", 64'(fq.out_pc_1), 64'(exp_pc + 32'h4));
      check("steady_tgt1", 64'(fq.out_pred_target_1), 64'(f_tgt(exp_pc + 32'h4)));
      check("steady_hist0", 64'(fq.out_pred_hist_0), 64'(f_hist(exp_pc)));
      check("steady_taken1", 64'(fq.out_pred_taken_1), 64'((exp_pc + 32'h4) >> 2) & 64'h1);
      exp_pc = exp_pc + 32'h8;
      tick();
    end
    check("steady_end_count", 64'(fq.count), 64'h5);

    // Occupancy 6, then flush with a valid push
    fq.stall = 1'b1;
    drive(2'b01, 32'h500, 32'h0);
    tick();
    check("six_count", 64'(fq.count), 64'h6);
    fq.flush = 1'b1;
    drive(2'b11, 32'h600, 32'h604);
    tick();
    fq.flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    check("flush_count", 64'(fq.count), 64'h0);
    check("flush_valid", 64'(fq.out_inst_valid), 64'h0);
    check("flush_ready", 64'(fq.in_ready), 64'h1);

    // Prediction fields after flush, both slots
    drive(2'b11, 32'h704, 32'h708);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("pred_pc0", 64'(fq.out_pc_0), 64'h704);
    check("pred_taken0", 64'(fq.out_pred_taken_0), 64'h1);
    check("pred_taken1", 64'(fq.out_pred_taken_1), 64'h0);
    check("pred_tgt0", 64'(fq.out_pred_target_0), 64'h744);
    check("pred_hist1", 64'(fq.out_pred_hist_1), 64'(8'hC2 ^ 8'h3C));

    // Asynchronous reset mid-cycle at occupancy 3
    drive(2'b01, 32'h70C, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("pre_areset_count", 64'(fq.count), 64'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_count", 64'(fq.count), 64'h0);
    check("areset_valid", 64'(fq.out_inst_valid), 64'h0);
    check("areset_pc0", 64'(fq.out_pc_0), 64'h0);
    check("areset_ready", 64'(fq.in_ready), 64'h1);
    tick();
    rst_n = 1'b1;

    // First post-reset enqueue
    fq.stall = 1'b0;
    drive(2'b11, 32'h800, 32'h804);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("post_rst_pc0", 64'(fq.out_pc_0), 64'h800);
    check("post_rst_pc1", 64'(fq.out_pc_1), 64'h804);
    tick();
    check("post_rst_empty", 64'(fq.count), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
